lift_tick_timer: RTL and testbench

Consumer side of the lift's slow-tick square wave: samples the divided-clock output in the fast `clk` domain, synchronizes it and converts each rising edge into a single-cycle `tick_pulse`. It then counts a programmable number of those ticks as a start/busy/done timer. The lift controller uses it for door-open hold time and per-floor travel time.

---
 rtl/lift_tick_timer.sv | 106 ++++++++++
 tb/tb_lift_tick_timer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lift_tick_timer.sv
// Slow-tick consumer for the lift: synchronizes the divided-clock square wave,
// turns each rising edge into a one-cycle tick_pulse and counts ticks as a start/busy/done timer.
module lift_tick_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic             tick_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   tick_pulse_q, tick_pulse_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Synchronizer, edge history and registered rising-edge pulse; independent of the FSM.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], tick_in};
        prev_d       = sync_q[SYNC_STAGES-1];
        tick_pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Timer next state: in RUN abort beats a tick, and start is never looked at.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        remaining_d = load_val;
                        state_d     = ST_RUN;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else if (tick_pulse_q) begin
                    if (remaining_q > CNT_W'(1)) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                remaining_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            tick_pulse_q <= 1'b0;
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            tick_pulse_q <= tick_pulse_d;
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign remaining  = remaining_q;
    assign tick_pulse = tick_pulse_q;

endmodule

// File: tb/tb_lift_tick_timer.sv
// Scoreboard bench for lift_tick_timer: expected tick_pulse and done cycles are queued
// as tick_in/start are driven and popped when the DUT raises the corresponding output.
module tb_lift_tick_timer;

    localparam int SYNC = 2;
    localparam int HALF = 25;

    logic       clk;
    logic       reset;
    logic       tick_in;
    logic       start;
    logic [7:0] load_val;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic       tick_pulse;

    int n_checks;
    int n_fail;
    int cyc;
    int pulse_cnt;
    logic prev_tp;
    int tick_q[$];
    int done_q[$];

    lift_tick_timer #(.SYNC_STAGES(SYNC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start(start),
        .load_val(load_val), .abort(abort), .busy(busy), .done(done),
        .remaining(remaining), .tick_pulse(tick_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard whenever a pulse appears.
    always @(negedge clk) begin
        if (tick_pulse) begin
            pulse_cnt++;
            check_val("tick_width", int'(prev_tp), 0);
            if (tick_q.size() == 0) check_val("tick_unexp", int'(tick_pulse), 0);
            else check_val("tick_cyc", cyc, tick_q.pop_front());
        end
        if (done) begin
            check_val("busy_at_done", int'(busy), 0);
            if (done_q.size() == 0) check_val("done_unexp", int'(done), 0);
            else check_val("done_cyc", cyc, done_q.pop_front());
        end
        prev_tp = tick_pulse;
    end

    // One 50-cycle tick_in period. mode 1: this tick completes the run; mode 2: abort with the pulse.
    task automatic tick_period(input int mode);
        int c;
        @(negedge clk);
        tick_in = 1'b1;
        c = cyc;
        tick_q.push_back(c + SYNC + 1);
        if (mode == 1) done_q.push_back(c + SYNC + 2);
        for (int i = 1; i < HALF; i++) begin
            @(negedge clk);
            abort = (mode == 2) && (cyc == c + SYNC + 1);
        end
        @(negedge clk);
        tick_in = 1'b0;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic do_start(input int val);
        @(negedge clk);
        start    = 1'b1;
        load_val = 8'(val);
        if (val == 0) done_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; pulse_cnt = 0; prev_tp = 1'b0;
        reset = 1'b1; tick_in = 1'b0; start = 1'b0; load_val = '0; abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_rem", int'(remaining), 0);
        check_val("rst_tick", int'(tick_pulse), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_val("idle_busy", int'(busy), 0);

        // Tick conversion: 10 periods with no timer running
        for (int i = 0; i < 10; i++) tick_period(0);
        check_val("tick_count", pulse_cnt, 10);
        check_val("idle_rem_after_ticks", int'(remaining), 0);

        // Normal run of 3
        do_start(3);
        check_val("run3_busy", int'(busy), 1);
        check_val("run3_rem", int'(remaining), 3);
        tick_period(0);
        check_val("run3_rem_t1", int'(remaining), 2);
        tick_period(0);
        check_val("run3_rem_t2", int'(remaining), 1);
        check_val("run3_busy_t2", int'(busy), 1);
        tick_period(1);
        check_val("run3_rem_t3", int'(remaining), 0);
        check_val("run3_busy_t3", int'(busy), 0);

        // Zero load: done next cycle, busy never rises
        do_start(0);
        check_val("zero_busy", int'(busy), 0);
        @(negedge clk);
        check_val("zero_busy2", int'(busy), 0);
        check_val("zero_rem", int'(remaining), 0);

        // Start during a run is ignored
        do_start(5);
        tick_period(0);
        check_val("ign_rem_t1", int'(remaining), 4);
        do_start(9);
        check_val("ign_rem_after_start", int'(remaining), 4);
        check_val("ign_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) tick_period(0);
        check_val("ign_rem_t4", int'(remaining), 1);
        tick_period(1);
        check_val("ign_rem_end", int'(remaining), 0);
        check_val("ign_busy_end", int'(busy), 0);

        // Abort after 2 of 5 ticks
        do_start(5);
        tick_period(0);
        tick_period(0);
        check_val("abort_rem_pre", int'(remaining), 3);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_rem", int'(remaining), 0);
        repeat (5) @(negedge clk);

        // Abort coinciding with the final tick
        do_start(1);
        tick_period(2);
        check_val("abort_fin_busy", int'(busy), 0);
        check_val("abort_fin_rem", int'(remaining), 0);

        // Asynchronous reset mid-run
        do_start(5);
        tick_period(0);
        check_val("mid_rem_pre", int'(remaining), 4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("mid_busy", int'(busy), 0);
        check_val("mid_rem", int'(remaining), 0);
        check_val("mid_done", int'(done), 0);
        check_val("mid_tick", int'(tick_pulse), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("post_rst_busy", int'(busy), 0);
        do_start(1);
        check_val("post_rst_rem", int'(remaining), 1);
        tick_period(1);
        check_val("post_rst_rem_end", int'(remaining), 0);

        // Width boundary: 255 ticks, no wrap
        do_start(255);
        check_val("w255_rem", int'(remaining), 255);
        for (int i = 0; i < 128; i++) tick_period(0);
        check_val("w255_rem_mid", int'(remaining), 127);
        for (int i = 0; i < 126; i++) tick_period(0);
        check_val("w255_rem_last", int'(remaining), 1);
        check_val("w255_busy_last", int'(busy), 1);
        tick_period(1);
        check_val("w255_rem_end", int'(remaining), 0);
        check_val("w255_busy_end", int'(busy), 0);
        repeat (5) @(negedge clk);
        check_val("w255_rem_hold", int'(remaining), 0);

        check_val("tick_q_empty", tick_q.size(), 0);
        check_val("done_q_empty", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
